// File: rtl/ov7670_dvp_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_dvp_pkg
// Shared definitions for the OV7670 DVP frame generator:
//   - dvp_state_t    : frame sequencer states
//   - MODE_*         : pattern select encodings on the mode input
//   - BAR_*          : the eight RGB565 colour-bar values, left to right
//   - lineBytes()    : byte slots per line (active plus blanking)
//   - barColour()    : bar index -> RGB565 colour
// ---------------------------------------------------------------------------
package ov7670_dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } dvp_state_t;

    localparam logic [1:0] MODE_BARS      = 2'd0;
    localparam logic [1:0] MODE_COUNTER   = 2'd1;
    localparam logic [1:0] MODE_SOLID     = 2'd2;
    localparam logic [1:0] MODE_BARS_RSVD = 2'd3;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    // Every pixel slot, active or blank, is two bytes on the wire.
    function automatic int lineBytes(input int hActive, input int hBlank);
        return (hActive + hBlank) << 1;
    endfunction

    function automatic logic [15:0] barColour(input logic [2:0] idx);
        logic [15:0] colour;
        case (idx)
            3'd0:    colour = BAR_WHITE;
            3'd1:    colour = BAR_YELLOW;
            3'd2:    colour = BAR_CYAN;
            3'd3:    colour = BAR_GREEN;
            3'd4:    colour = BAR_MAGENTA;
            3'd5:    colour = BAR_RED;
            3'd6:    colour = BAR_BLUE;
            default: colour = BAR_BLACK;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/ov7670_dvp_gen_pattern.sv
// ---------------------------------------------------------------------------
// dvp_pattern_src
// Produces the 16-bit RGB565 pixel for the current column of an active line.
// Ports:
//   clk, rst       : clock and asynchronous active-high reset
//   i_px           : pixel column within the active line
//   i_pixAdvance   : one-cycle strobe after a pixel's low byte has been sent
//   i_frameStart   : one-cycle strobe when a new frame is launched
//   i_mode         : latched pattern select (MODE_*)
//   i_solid        : latched solid colour
//   o_pix          : pixel value for the current column
// ---------------------------------------------------------------------------
module dvp_pattern_src
    import ov7670_dvp_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int PX_W     = $clog2(H_ACTIVE)
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic [PX_W-1:0] i_px,
    input  logic            i_pixAdvance,
    input  logic            i_frameStart,
    input  logic [1:0]      i_mode,
    input  logic [15:0]     i_solid,
    output logic [15:0]     o_pix
);

    // Bar index is tracked with a pixels-within-bar counter instead of
    // dividing the column by the bar width.
    localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
    localparam int BC_W  = $clog2(BAR_W) + 1;
    localparam logic [BC_W-1:0] BAR_LAST = BC_W'(BAR_W - 1);
    localparam logic [PX_W-1:0] PX_LAST  = PX_W'(H_ACTIVE - 1);

    logic [15:0]     r_pixCount;
    logic [2:0]      r_barIdx;
    logic [BC_W-1:0] r_barPos;

    // Running pixel index for counter mode plus the bar position for bar
    // mode. The bar restarts at the end of every line and saturates at the
    // last bar when the line is not a multiple of eight pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pixCount <= 16'd0;
            r_barIdx   <= 3'd0;
            r_barPos   <= '0;
        end else if (i_frameStart) begin
            r_pixCount <= 16'd0;
            r_barIdx   <= 3'd0;
            r_barPos   <= '0;
        end else if (i_pixAdvance) begin
            r_pixCount <= r_pixCount + 16'd1;
            if (i_px == PX_LAST) begin
                r_barIdx <= 3'd0;
                r_barPos <= '0;
            end else if (r_barPos == BAR_LAST) begin
                r_barPos <= '0;
                if (r_barIdx != 3'd7) begin
                    r_barIdx <= r_barIdx + 3'd1;
                end
            end else begin
                r_barPos <= r_barPos + BC_W'(1);
            end
        end
    end

    // Pattern select; both bar encodings share the colour-bar pattern.
    always_comb begin
        o_pix = barColour(r_barIdx);
        case (i_mode)
            MODE_COUNTER:              o_pix = r_pixCount;
            MODE_SOLID:                o_pix = i_solid;
            MODE_BARS, MODE_BARS_RSVD: o_pix = barColour(r_barIdx);
            default:                   o_pix = barColour(r_barIdx);
        endcase
    end

endmodule

// File: rtl/ov7670_dvp_gen.sv
// ---------------------------------------------------------------------------
// ov7670_dvp_gen
// OV7670 camera emulator driving the DVP bus with RGB565 test frames.
// Ports:
//   clock_24mhz : system clock (XCLK equivalent)
//   reset       : asynchronous active-high reset
//   enable      : frames are generated while high (sampled at frame bounds)
//   mode        : 0 bars, 1 pixel counter, 2 solid, 3 bars
//   solid_rgb   : colour for solid mode
//   pclk        : pixel clock, clock_24mhz / 2
//   vsync       : frame sync, active high
//   href        : line valid, active high
//   data        : pixel byte, high byte first
//   frame_done  : one-clock pulse at the end of each frame
//   frame_count : completed frames, wrapping
//   busy        : high from frame start to frame_done
// ---------------------------------------------------------------------------
module ov7670_dvp_gen
    import ov7670_dvp_pkg::*;
#(
    parameter int          H_ACTIVE      = 640,
    parameter int          V_ACTIVE      = 480,
    parameter int          H_BLANK       = 144,
    parameter int          VS_LINES      = 3,
    parameter int          VBP           = 17,
    parameter int          VFP           = 10,
    parameter logic [15:0] SOLID_DEFAULT = 16'hF800
)
(
    input  logic        clock_24mhz,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_rgb,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam int LINE_BYTES = lineBytes(H_ACTIVE, H_BLANK);
    localparam int BX_W       = $clog2(LINE_BYTES);
    localparam int PX_W       = $clog2(H_ACTIVE);
    localparam int LY_MAX_A   = (V_ACTIVE > VBP) ? V_ACTIVE : VBP;
    localparam int LY_MAX_B   = (VS_LINES > VFP) ? VS_LINES : VFP;
    localparam int LY_MAX     = (LY_MAX_A > LY_MAX_B) ? LY_MAX_A : LY_MAX_B;
    localparam int LY_W       = $clog2(LY_MAX + 1);

    localparam logic [BX_W-1:0] BX_LAST    = BX_W'(LINE_BYTES - 1);
    localparam logic [BX_W-1:0] HREF_BYTES = BX_W'(H_ACTIVE << 1);
    localparam logic [LY_W-1:0] LY_VS_LAST = LY_W'(VS_LINES - 1);
    localparam logic [LY_W-1:0] LY_VB_LAST = LY_W'(VBP - 1);
    localparam logic [LY_W-1:0] LY_VA_LAST = LY_W'(V_ACTIVE - 1);
    localparam logic [LY_W-1:0] LY_VF_LAST = LY_W'(VFP - 1);

    dvp_state_t       r_state;
    logic             r_pclk;
    logic [BX_W-1:0]  r_bx;
    logic [LY_W-1:0]  r_ly;
    logic             r_vsync;
    logic             r_href;
    logic [7:0]       r_data;
    logic             r_frameDone;
    logic [15:0]      r_frameCount;
    logic             r_busy;
    logic [1:0]       r_mode;
    logic [15:0]      r_solid;

    logic             w_tick;
    logic             w_lineEnd;
    logic             w_lastLine;
    dvp_state_t       w_nextState;
    logic             w_activeByte;
    logic             w_frameEnd;
    logic             w_frameStart;
    logic             w_pixAdvance;
    logic [PX_W-1:0]  w_px;
    logic [15:0]      w_pix;
    logic [7:0]       w_byte;

    // A tick is the cycle where pclk falls, so everything launched on a tick
    // is settled by the next pclk rising edge where the receiver samples.
    assign w_tick       = r_pclk;
    assign w_lineEnd    = (r_bx == BX_LAST);
    assign w_activeByte = (r_state == ST_ACTIVE) && (r_bx < HREF_BYTES);
    assign w_frameEnd   = w_tick && (r_state == ST_VFRONT) && w_lineEnd && w_lastLine;
    assign w_frameStart = w_tick && enable && ((r_state == ST_IDLE) || w_frameEnd);
    assign w_pixAdvance = w_tick && w_activeByte && r_bx[0];
    assign w_px         = r_bx[PX_W:1];
    assign w_byte       = r_bx[0] ? w_pix[7:0] : w_pix[15:8];

    // Line budget of the current state and where the sequencer goes after it.
    always_comb begin
        w_lastLine  = 1'b0;
        w_nextState = ST_IDLE;
        case (r_state)
            ST_VSYNC: begin
                w_lastLine  = (r_ly == LY_VS_LAST);
                w_nextState = ST_VBACK;
            end
            ST_VBACK: begin
                w_lastLine  = (r_ly == LY_VB_LAST);
                w_nextState = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                w_lastLine  = (r_ly == LY_VA_LAST);
                w_nextState = ST_VFRONT;
            end
            ST_VFRONT: begin
                w_lastLine  = (r_ly == LY_VF_LAST);
                w_nextState = enable ? ST_VSYNC : ST_IDLE;
            end
            default: begin
                w_lastLine  = 1'b0;
                w_nextState = ST_IDLE;
            end
        endcase
    end

    dvp_pattern_src #(
        .H_ACTIVE (H_ACTIVE),
        .PX_W     (PX_W)
    ) u_pattern (
        .clk          (clock_24mhz),
        .rst          (reset),
        .i_px         (w_px),
        .i_pixAdvance (w_pixAdvance),
        .i_frameStart (w_frameStart),
        .i_mode       (r_mode),
        .i_solid      (r_solid),
        .o_pix        (w_pix)
    );

    // Frame sequencer and bus outputs. Outputs on each tick reflect the slot
    // the counters point at, so the bus runs one slot behind the counters;
    // the first vsync slot therefore appears on the tick after the IDLE tick.
    always_ff @(posedge clock_24mhz or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pclk       <= 1'b0;
            r_bx         <= '0;
            r_ly         <= '0;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_data       <= 8'h00;
            r_frameDone  <= 1'b0;
            r_frameCount <= 16'd0;
            r_busy       <= 1'b0;
            r_mode       <= MODE_BARS;
            r_solid      <= SOLID_DEFAULT;
        end else begin
            r_pclk      <= ~r_pclk;
            r_frameDone <= 1'b0;
            if (w_tick) begin
                r_vsync <= (r_state == ST_VSYNC);
                r_href  <= w_activeByte;
                r_data  <= w_activeByte ? w_byte : 8'h00;

                // Back-to-back frames keep busy high: the start overrides
                // the clear from the end of the previous frame.
                if (w_frameEnd) begin
                    r_frameDone  <= 1'b1;
                    r_frameCount <= r_frameCount + 16'd1;
                    r_busy       <= 1'b0;
                end
                if (w_frameStart) begin
                    r_mode  <= mode;
                    r_solid <= solid_rgb;
                    r_busy  <= 1'b1;
                end

                if (r_state == ST_IDLE) begin
                    r_bx <= '0;
                    r_ly <= '0;
                    if (enable) begin
                        r_state <= ST_VSYNC;
                    end
                end else if (w_lineEnd) begin
                    r_bx <= '0;
                    if (w_lastLine) begin
                        r_ly    <= '0;
                        r_state <= w_nextState;
                    end else begin
                        r_ly <= r_ly + LY_W'(1);
                    end
                end else begin
                    r_bx <= r_bx + BX_W'(1);
                end
            end
        end
    end

    assign pclk        = r_pclk;
    assign vsync       = r_vsync;
    assign href        = r_href;
    assign data        = r_data;
    assign frame_done  = r_frameDone;
    assign frame_count = r_frameCount;
    assign busy        = r_busy;

endmodule

// File: tb/tb_ov7670_dvp_gen.sv
// ---------------------------------------------------------------------------
// tb_ov7670_dvp_gen
// Scoreboard bench for ov7670_dvp_gen on a reduced frame geometry.
// A reference process builds each frame as a list of {vsync, href, data}
// slots from the frame rules and queues one slot per pixel-clock tick; a
// monitor compares the bus, pclk, frame_done, busy and frame_count every
// clock against the queue and the reference counters.
// ---------------------------------------------------------------------------
module tb_ov7670_dvp_gen;

    localparam int HA    = 8;
    localparam int HB    = 4;
    localparam int VA    = 4;
    localparam int VS    = 1;
    localparam int VB    = 1;
    localparam int VF    = 1;
    localparam int LB    = 2 * HA + 2 * HB;
    localparam int LINES = VS + VB + VA + VF;
    localparam int SLOTS = LB * LINES;

    localparam logic [1:0] M_BARS    = 2'd0;
    localparam logic [1:0] M_COUNTER = 2'd1;
    localparam logic [1:0] M_SOLID   = 2'd2;

    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic        clock_24mhz = 1'b0;
    logic        reset       = 1'b1;
    logic        enable      = 1'b0;
    logic [1:0]  mode        = 2'd0;
    logic [15:0] solid_rgb   = 16'h0000;
    logic        pclk;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        busy;

    ov7670_dvp_gen #(
        .H_ACTIVE      (HA),
        .V_ACTIVE      (VA),
        .H_BLANK       (HB),
        .VS_LINES      (VS),
        .VBP           (VB),
        .VFP           (VF),
        .SOLID_DEFAULT (16'hF800)
    ) dut (
        .clock_24mhz (clock_24mhz),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .solid_rgb   (solid_rgb),
        .pclk        (pclk),
        .vsync       (vsync),
        .href        (href),
        .data        (data),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .busy        (busy)
    );

    always #5 clock_24mhz = ~clock_24mhz;

    int          vectors;
    int          miscompares;
    logic [9:0]  expQ [$];
    logic [9:0]  frameBuf [SLOTS];
    int          cnt;
    bit          inFrame;
    int          slotIdx;
    logic        expDone;
    logic        expBusy;
    logic [15:0] expCount;
    logic [9:0]  monExp;

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] m, input logic [15:0] sol);
        enable    = en;
        mode      = m;
        solid_rgb = sol;
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clock_24mhz);
    endtask

    task automatic waitFrameEnd();
        int n;
        n = 0;
        @(negedge clock_24mhz);
        while (!expDone && n < 1000) begin
            @(negedge clock_24mhz);
            n++;
        end
        if (!expDone) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL frame_end_timeout: got no frame end, expected one within 1000 clocks");
        end
    endtask

    task automatic releaseReset();
        @(negedge clock_24mhz);
        #2 reset = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pclk"},        16'(pclk),        16'h0);
        checkOutput({tag, "_vsync"},       16'(vsync),       16'h0);
        checkOutput({tag, "_href"},        16'(href),        16'h0);
        checkOutput({tag, "_data"},        16'(data),        16'h0);
        checkOutput({tag, "_frame_done"},  16'(frame_done),  16'h0);
        checkOutput({tag, "_frame_count"}, frame_count,      16'h0);
        checkOutput({tag, "_busy"},        16'(busy),        16'h0);
    endtask

    // Expected {vsync, href, data} for slot s of a frame, straight from the
    // frame layout: line = s / LB, byte = s % LB.
    function automatic logic [9:0] refSlot(input int s, input logic [1:0] m, input logic [15:0] sol);
        int          line;
        int          b;
        int          row;
        int          px;
        int          bar;
        logic        v;
        logic        h;
        logic [15:0] pix;
        logic [7:0]  d;
        line = s / LB;
        b    = s % LB;
        row  = line - VS - VB;
        v    = (line < VS);
        h    = (row >= 0) && (row < VA) && (b < 2 * HA);
        px   = b / 2;
        bar  = px / (HA / 8);
        if (bar > 7) bar = 7;
        case (m)
            M_COUNTER: pix = 16'(row * HA + px);
            M_SOLID:   pix = sol;
            default:   pix = BARS[bar];
        endcase
        if (!h)             d = 8'h00;
        else if (b % 2 == 0) d = pix[15:8];
        else                d = pix[7:0];
        return {v, h, d};
    endfunction

    task automatic startFrame();
        for (int s = 0; s < SLOTS; s++) begin
            frameBuf[s] = refSlot(s, mode, solid_rgb);
        end
        inFrame = 1'b1;
        slotIdx = 0;
        expBusy = 1'b1;
    endtask

    // Reference: one expected bus slot per tick (every second clock after
    // reset release); frames launch whenever enable is seen at a boundary.
    initial begin : model
        cnt      = 0;
        inFrame  = 1'b0;
        slotIdx  = 0;
        expDone  = 1'b0;
        expBusy  = 1'b0;
        expCount = 16'h0000;
        forever begin
            @(posedge clock_24mhz);
            if (reset) begin
                cnt      = 0;
                inFrame  = 1'b0;
                slotIdx  = 0;
                expDone  = 1'b0;
                expBusy  = 1'b0;
                expCount = 16'h0000;
                expQ.delete();
            end else begin
                cnt++;
                expDone = 1'b0;
                if (cnt % 2 == 0) begin
                    if (inFrame) begin
                        expQ.push_back(frameBuf[slotIdx]);
                        if (slotIdx == SLOTS - 1) begin
                            expDone  = 1'b1;
                            expCount = expCount + 16'd1;
                            expBusy  = 1'b0;
                            inFrame  = 1'b0;
                            if (enable) startFrame();
                        end else begin
                            slotIdx++;
                        end
                    end else begin
                        expQ.push_back(10'd0);
                        if (enable) startFrame();
                    end
                end
            end
        end
    end

    // Monitor: mid-clock sampling. With pclk low the bus must already show
    // the slot launched on the tick; with pclk high it must still show it.
    initial begin : monitor
        forever begin
            @(negedge clock_24mhz);
            if (!reset && cnt > 0) begin
                checkOutput("pclk", 16'(pclk), 16'((cnt % 2 == 1) ? 1 : 0));
                if (expQ.size() == 0) begin
                    monExp = 10'd0;
                end else if (cnt % 2 == 1) begin
                    monExp = expQ.pop_front();
                end else begin
                    monExp = expQ[0];
                end
                checkOutput("dvp_bus", 16'({vsync, href, data}), 16'(monExp));
                checkOutput("frame_done", 16'(frame_done), 16'(expDone));
                checkOutput("busy", 16'(busy), 16'(expBusy));
                checkOutput("frame_count", frame_count, expCount);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, expected one before t=1000000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        vectors     = 0;
        miscompares = 0;

        applyStimulus(1'b1, M_BARS, 16'h1234);
        waitClocks(3);
        checkResetValues("reset");
        releaseReset();

        // Colour bars, then counter mode changed mid-frame.
        waitFrameEnd();
        waitClocks(100);
        applyStimulus(1'b1, M_COUNTER, 16'h1234);
        waitFrameEnd();
        waitFrameEnd();

        // Solid colour; mid-frame colour change only affects the next frame.
        applyStimulus(1'b1, M_SOLID, 16'h1234);
        waitFrameEnd();
        waitClocks(150);
        applyStimulus(1'b1, M_SOLID, 16'hABCD);
        waitFrameEnd();
        waitFrameEnd();

        // Randomised mode/colour changes at random points in the frame.
        for (int f = 0; f < 4; f++) begin
            waitClocks($urandom_range(20, 300));
            applyStimulus(1'b1, 2'($urandom_range(0, 3)), 16'($urandom));
            waitFrameEnd();
        end

        // Drop enable in the middle of the active region.
        waitClocks(2 * LB * 3 + 10);
        applyStimulus(1'b0, M_BARS, 16'h0F0F);
        waitFrameEnd();
        waitClocks(40);
        checkOutput("idle_busy", 16'(busy), 16'h0);
        checkOutput("idle_vsync", 16'(vsync), 16'h0);

        // Preload the frame counter and run one frame across the wrap.
        @(negedge clock_24mhz);
        #2;
        force dut.r_frameCount = 16'hFFFF;
        expCount = 16'hFFFF;
        #1;
        release dut.r_frameCount;
        waitClocks(2);
        applyStimulus(1'b1, M_COUNTER, 16'h5A5A);
        waitFrameEnd();
        checkOutput("count_wrap", frame_count, 16'h0000);

        // Reset in the middle of the active region, then restart.
        waitClocks(2 * LB * 3 + 10);
        #2 reset = 1'b1;
        #1;
        checkResetValues("mid_reset");
        waitClocks(3);
        releaseReset();
        waitFrameEnd();
        waitClocks(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
